// File: rtl/tlp_fifo_arb.sv
// rtl/tlp_fifo_arb.sv - packet-granular round-robin arbiter merging TLP FWFT FIFOs
//
// Presents NUM_SRC first-word-fall-through TLP FIFOs to the encapsulator as
// one FWFT FIFO. A grant is held from the first word of a TLP until the
// word with last set is popped.
//
// Ports:
//   clk156       datapath clock
//   sys_rst_n    asynchronous active-low reset
//   src_empty    per-source FWFT empty
//   src_dout     per-source FWFT head word, source i at [i*WORD_W +: WORD_W]
//   src_rd_en    per-source pop
//   src_mask     per-source eligibility for new grants
//   m_rd_en      pop request from the encapsulator
//   m_dout       head word of the granted source (0 when idle)
//   m_empty      merged empty (1 when idle)
//   grant_valid  a source is locked
//   grant_idx    locked source index (drives the TCAP dir field)
//   pkt_cnt      completed packets per source, source i at [i*CNT_W +: CNT_W]
//
// Word layout: [73:66] tkeep, [65:2] tdata, [1] last, [0] user.

module tlp_fifo_arb #(
    parameter int NUM_SRC = 2,
    parameter int WORD_W  = 74,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       clk156,
    input  logic                       sys_rst_n,
    input  logic [NUM_SRC-1:0]         src_empty,
    input  logic [NUM_SRC*WORD_W-1:0]  src_dout,
    output logic [NUM_SRC-1:0]         src_rd_en,
    input  logic [NUM_SRC-1:0]         src_mask,
    input  logic                       m_rd_en,
    output logic [WORD_W-1:0]          m_dout,
    output logic                       m_empty,
    output logic                       grant_valid,
    output logic [IDX_W-1:0]           grant_idx,
    output logic [NUM_SRC*CNT_W-1:0]   pkt_cnt
);

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    arb_state_t          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]    cnt_q    [NUM_SRC];
    logic [WORD_W-1:0]   src_word [NUM_SRC];

    logic [NUM_SRC-1:0]  cand;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    scan_idx;

    logic                locked;
    logic                head_empty;
    logic                head_last;
    logic                pop_ok;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slice
        assign src_word[g]                 = src_dout[g*WORD_W +: WORD_W];
        assign pkt_cnt[g*CNT_W +: CNT_W]   = cnt_q[g];
    end

    // Round-robin search: scanning offsets from highest to lowest and letting
    // later hits overwrite earlier ones leaves the candidate closest to rr_ptr.
    always_comb begin
        cand       = ~src_empty & src_mask;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            scan_idx = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (cand[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign locked     = (state == ARB_LOCK);
    assign head_empty = src_empty[grant_idx];
    assign head_last  = src_word[grant_idx][1];
    // An underrunning source keeps the grant; pops simply stall while empty.
    assign pop_ok     = locked & m_rd_en & ~head_empty;

    assign m_empty = locked ? head_empty : 1'b1;
    assign m_dout  = locked ? src_word[grant_idx] : '0;

    always_comb begin
        src_rd_en = '0;
        if (pop_ok) begin
            src_rd_en[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ARB_IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            rr_ptr      <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        state       <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    // Mask changes are ignored here so a locked packet always completes.
                    if (pop_ok && head_last) begin
                        state            <= ARB_IDLE;
                        grant_valid      <= 1'b0;
                        rr_ptr           <= (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0
                                                                              : grant_idx + 1'b1;
                        cnt_q[grant_idx] <= cnt_q[grant_idx] + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= ARB_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlp_fifo_arb.sv
// tb/tb_tlp_fifo_arb.sv - self-checking bench for tlp_fifo_arb

module tb_tlp_fifo_arb;

    localparam int WW = 74;
    localparam int CW = 4;

    logic           clk156;
    logic           sys_rst_n;
    logic [1:0]     src_empty;
    logic [2*WW-1:0] src_dout;
    logic [1:0]     src_rd_en;
    logic [1:0]     src_mask;
    logic           m_rd_en;
    logic [WW-1:0]  m_dout;
    logic           m_empty;
    logic           grant_valid;
    logic [0:0]     grant_idx;
    logic [2*CW-1:0] pkt_cnt;

    tlp_fifo_arb #(.NUM_SRC(2), .WORD_W(WW), .CNT_W(CW)) dut (
        .clk156      (clk156),
        .sys_rst_n   (sys_rst_n),
        .src_empty   (src_empty),
        .src_dout    (src_dout),
        .src_rd_en   (src_rd_en),
        .src_mask    (src_mask),
        .m_rd_en     (m_rd_en),
        .m_dout      (m_dout),
        .m_empty     (m_empty),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .pkt_cnt     (pkt_cnt)
    );

    initial clk156 = 1'b0;
    always #5 clk156 = ~clk156;

    int n_cmp  = 0;
    int n_fail = 0;

    // Source FIFO emulation
    logic [WW-1:0] fifo [2][$];
    logic [1:0]    hold;
    logic [1:0]    drv_empty;
    logic [WW-1:0] drv_word [2];
    logic [1:0]    rd_cap;

    // Reference model state
    bit   mdl_busy;
    int   mdl_src;
    int   mdl_ptr;
    int   mdl_cnt [2];
    bit   mdl_found;

    logic [WW-1:0] exp_dout;
    logic          exp_empty;
    logic [1:0]    exp_rd;
    logic          prev_gv;

    int            grant_log [$];
    int            pop_src_log [$];
    logic [WW-1:0] dout_log [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] make_word(input int src, input int pkt, input int idx,
                                                input bit last, input bit user);
        logic [63:0] d;
        d = {16'hC0DE, 8'(src), 8'(pkt), 16'(idx), 16'hA5A5};
        return {8'hFF, d, last, user};
    endfunction

    task automatic push_pkt(input int src, input int pkt, input int n, input bit user);
        for (int w = 0; w < n; w++) begin
            fifo[src].push_back(make_word(src, pkt, w, (w == n - 1), user));
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < 2; i++) begin
            drv_empty[i] = (fifo[i].size() == 0) || hold[i];
            drv_word[i]  = (fifo[i].size() == 0) ? '0 : fifo[i][0];
        end
        src_empty = drv_empty;
        src_dout  = {drv_word[1], drv_word[0]};
    endtask

    task automatic clear_fifos();
        fifo[0].delete();
        fifo[1].delete();
        hold = 2'b00;
        drive_src();
    endtask

    task automatic tick();
        @(posedge clk156);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rd_cap[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
        rd_cap = 2'b00;
        drive_src();
    endtask

    task automatic drain(input int max_cyc, output int n);
        n = 0;
        while (!(mdl_busy == 0 && fifo[0].size() == 0 && fifo[1].size() == 0) && n < max_cyc) begin
            tick();
            n++;
        end
        if (n >= max_cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: no drain within %0d cycles", max_cyc);
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick();
        tick();
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_m_empty", m_empty, 1);
        chk("rst_src_rd_en", src_rd_en, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        grant_log.delete();
        pop_src_log.delete();
        dout_log.delete();
        sys_rst_n = 1'b1;
    endtask

    // Compare process: checks outputs against the model, then advances the
    // model with the inputs that will be present at the coming rising edge.
    always @(negedge clk156) begin
        if (!sys_rst_n) begin
            mdl_busy   = 0;
            mdl_src    = 0;
            mdl_ptr    = 0;
            mdl_cnt[0] = 0;
            mdl_cnt[1] = 0;
        end
        exp_empty = mdl_busy ? drv_empty[mdl_src] : 1'b1;
        exp_dout  = mdl_busy ? drv_word[mdl_src] : '0;
        exp_rd    = 2'b00;
        if (mdl_busy && m_rd_en && !drv_empty[mdl_src]) exp_rd[mdl_src] = 1'b1;

        chk("grant_valid", grant_valid, mdl_busy);
        chk("grant_idx", grant_idx, mdl_src);
        chk("m_empty", m_empty, exp_empty);
        chk("m_dout", m_dout, exp_dout);
        chk("src_rd_en", src_rd_en, exp_rd);
        chk("pkt_cnt", pkt_cnt, {4'(mdl_cnt[1]), 4'(mdl_cnt[0])});

        rd_cap = src_rd_en;
        if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_idx));
        prev_gv = grant_valid;
        if (src_rd_en != 2'b00) pop_src_log.push_back(src_rd_en[1] ? 1 : 0);
        if (m_rd_en && !m_empty) dout_log.push_back(m_dout);

        if (sys_rst_n) begin
            if (!mdl_busy) begin
                mdl_found = 0;
                for (int k = 0; k < 2; k++) begin
                    if (!mdl_found && !drv_empty[(mdl_ptr + k) % 2] && src_mask[(mdl_ptr + k) % 2]) begin
                        mdl_found = 1;
                        mdl_src   = (mdl_ptr + k) % 2;
                    end
                end
                mdl_busy = mdl_found;
            end else if (m_rd_en && !drv_empty[mdl_src] && drv_word[mdl_src][1]) begin
                mdl_busy         = 0;
                mdl_cnt[mdl_src] = (mdl_cnt[mdl_src] + 1) % 16;
                mdl_ptr          = (mdl_src + 1) % 2;
            end
        end
    end

    int n;
    int exp_alt [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        sys_rst_n = 1'b0;
        m_rd_en   = 1'b0;
        src_mask  = 2'b11;
        rd_cap    = 2'b00;
        prev_gv   = 1'b0;
        clear_fifos();

        // Reset with data waiting, then alternation of 3x 4-word packets each
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, p, 4, 0);
            push_pkt(1, p, 4, 0);
        end
        drive_src();
        do_reset();
        m_rd_en = 1'b1;
        tick();
        chk("first_grant_valid", grant_valid, 1);
        chk("first_grant_idx", grant_idx, 0);
        chk("first_m_empty", m_empty, 0);
        drain(200, n);
        chk("alt_cycles", 1 + n, 30);
        chk("alt_grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("alt_grant_seq", grant_log[i], exp_alt[i]);
        chk("alt_pkt_cnt", pkt_cnt, 8'h33);

        // Atomicity: src1 arrives mid-way through a 6-word src0 packet
        clear_fifos();
        m_rd_en = 1'b0;
        push_pkt(0, 0, 6, 0);
        drive_src();
        do_reset();
        m_rd_en = 1'b1;
        tick();
        tick();
        tick();
        push_pkt(1, 0, 2, 0);
        drive_src();
        drain(100, n);
        chk("atom_pop_count", pop_src_log.size(), 8);
        for (int i = 0; i < 8 && i < pop_src_log.size(); i++) chk("atom_pop_src", pop_src_log[i], (i < 6) ? 0 : 1);
        chk("atom_grants", grant_log.size(), 2);

        // Underrun after word 2 of 5, held for 10 cycles
        clear_fifos();
        m_rd_en = 1'b0;
        push_pkt(0, 0, 5, 0);
        drive_src();
        do_reset();
        m_rd_en = 1'b1;
        tick();
        tick();
        tick();
        hold[0] = 1'b1;
        drive_src();
        for (int i = 0; i < 10; i++) tick();
        chk("under_m_empty", m_empty, 1);
        chk("under_grant_valid", grant_valid, 1);
        chk("under_rd_en", src_rd_en, 0);
        chk("under_left", fifo[0].size(), 3);
        hold[0] = 1'b0;
        drive_src();
        drain(100, n);
        chk("under_words", dout_log.size(), 5);
        for (int i = 0; i < 5 && i < dout_log.size(); i++) chk("under_data", dout_log[i], make_word(0, 0, i, i == 4, 0));

        // Mask: only src1 eligible, then unmask src0 mid-packet
        clear_fifos();
        m_rd_en  = 1'b0;
        src_mask = 2'b10;
        push_pkt(0, 0, 3, 0);
        push_pkt(1, 0, 3, 0);
        drive_src();
        do_reset();
        m_rd_en = 1'b1;
        tick();
        tick();
        src_mask = 2'b11;
        drain(100, n);
        chk("mask_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("mask_first", grant_log[0], 1);
            chk("mask_second", grant_log[1], 0);
        end

        // Counter wrap: 17 single-word packets, user bit set on packet 5
        clear_fifos();
        m_rd_en = 1'b0;
        for (int p = 0; p < 17; p++) push_pkt(0, p, 1, (p == 5));
        drive_src();
        do_reset();
        m_rd_en = 1'b1;
        drain(200, n);
        chk("wrap_cnt0", pkt_cnt[3:0], 1);
        chk("wrap_cnt1", pkt_cnt[7:4], 0);
        chk("wrap_words", dout_log.size(), 17);
        if (dout_log.size() == 17) begin
            chk("user_set", dout_log[5], make_word(0, 5, 0, 1, 1));
            chk("user_clear", dout_log[4][0], 0);
        end

        // Reset mid-packet drops the grant at once
        clear_fifos();
        m_rd_en = 1'b0;
        push_pkt(0, 0, 4, 0);
        drive_src();
        do_reset();
        m_rd_en = 1'b1;
        tick();
        tick();
        tick();
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_grant_valid", grant_valid, 0);
        chk("midrst_m_empty", m_empty, 1);
        chk("midrst_rd_en", src_rd_en, 0);
        tick();
        sys_rst_n = 1'b1;
        drain(100, n);
        chk("midrst_words", dout_log.size(), 4);
        if (dout_log.size() == 4) chk("midrst_tail", dout_log[3], make_word(0, 0, 3, 1, 0));
        chk("midrst_cnt", pkt_cnt, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tlp_fifo_arb.md
# tlp_fifo_arb

Packet-granular round-robin arbiter that shares the single Ethernet/UDP encapsulation TX path between several captured-TLP FIFOs (e.g. upstream and downstream capture directions). It sits between the per-direction first-word-fall-through TLP FIFOs and the encapsulator's FIFO read port, and presents itself to the encapsulator as one FWFT FIFO. It holds a grant for a whole TLP, from first word to the word with `last` set, and exposes the granted source index for the TCAP `dir` field. It also keeps per-source packet counters.

## Interface
- `NUM_SRC`, 2, number of requesting FIFOs (2..8).
- `WORD_W`, 74, FIFO word width; layout [73:66] tkeep, [65:2] tdata, [1] last, [0] user.
- `CNT_W`, 32, width of each per-source packet counter.
- `clk156`  in  1  datapath clock.
- `sys_rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `src_empty`  in  NUM_SRC  per-source FWFT FIFO empty.
- `src_dout`  in  NUM_SRC×WORD_W  per-source FWFT head word.
- `src_rd_en`  out  NUM_SRC  per-source pop.
- `src_mask`  in  NUM_SRC  1 = source eligible for new grants (static config, sampled only in IDLE).
- `m_rd_en`  in  1  pop from encapsulator.
- `m_dout`  out  WORD_W  head word of granted source.
- `m_empty`  out  1  merged empty seen by encapsulator.
- `grant_valid`  out  1  a source is locked.
- `grant_idx`  out  $clog2(NUM_SRC) (min 1)  locked source index.
- `pkt_cnt`  out  NUM_SRC×CNT_W  completed packets forwarded per source.

## Operation
- FSM states: ARB_IDLE, ARB_LOCK.
- ARB_IDLE:
  - Candidate set = `~src_empty & src_mask`.
  - If the set is non-empty, pick the first candidate searching from `rr_ptr` upward with wrap.
  - Register `grant_idx`, set `grant_valid`, go to ARB_LOCK.
- ARB_LOCK:
  - `m_dout = src_dout[grant_idx]` and `m_empty = src_empty[grant_idx]`, both combinational.
  - `src_rd_en[grant_idx] = m_rd_en & ~src_empty[grant_idx]`; every other `src_rd_en` bit is 0.
  - A pop is accepted when `m_rd_en & ~m_empty`.
  - An accepted pop with `m_dout[1]` = 1 ends the packet: return to ARB_IDLE, set `rr_ptr` = (grant_idx+1) mod NUM_SRC, increment `pkt_cnt[grant_idx]`.
- In ARB_IDLE, `m_empty` = 1, `m_dout` = 0, and all `src_rd_en` = 0. `m_rd_en` is ignored.
- `m_rd_en` while `m_empty` = 1 has no effect and is never forwarded. A granted source that underruns mid-packet keeps the grant until its `last` word is popped.
- `src_mask` changes take effect only at the next IDLE decision. Clearing the mask bit of the locked source does not abort its packet.
- `pkt_cnt` wraps modulo 2^CNT_W with no saturation.
- `m_dout[0]` (user) is passed through unchanged; the arbiter does not drop errored packets.

## Timing
- Reset (async assert) forces:
  - state ARB_IDLE, `grant_valid` 0, `grant_idx` 0, `rr_ptr` 0, all `pkt_cnt` 0.
  - combinationally, `m_empty` 1, `m_dout` 0, `src_rd_en` 0.
- Deassertion is synchronised to `clk156` by the caller.
- Grant latency: candidate present at edge N → `grant_valid`=1 and `m_empty`=`src_empty[grant_idx]` after edge N+1.
- Release: a `last` pop at edge N → ARB_IDLE after edge N. A new grant needs at least one IDLE cycle, so the minimum bubble between packets is 1 cycle.
- Back-to-back pops are supported at one word per cycle while locked.
- Simultaneous `last` pop and new source becoming non-empty: the new source is considered in the following IDLE cycle, under the updated `rr_ptr`.
- Reset mid-packet: grant is dropped immediately. Words left in the source FIFO are not flushed; the system reset also resets the encapsulator.

## Test plan
- Reset: `src_empty`=2'b00 during `sys_rst_n`=0 → `grant_valid`=0, `m_empty`=1, `src_rd_en`=0, `pkt_cnt`=0. After release → grant to src0 one cycle later.
- Alternation: both sources hold three 4-word packets, `m_rd_en`=1 constant → grant sequence 0,1,0,1,0,1; one idle cycle between packets; `pkt_cnt`={3,3}.
- Packet atomicity: src1 becomes non-empty while src0's 6-word packet is mid-transfer → no `src_rd_en[1]` pulse until after src0's `last` pop; `grant_idx` stays 0 for all 6 words.
- Underrun: src0 goes empty after word 2 of 5 for 10 cycles with `m_rd_en`=1 → `m_empty`=1, no pops, grant held; words 3-5 are forwarded once data resumes.
- Mask: `src_mask`=2'b10 with both sources non-empty → only src1 granted. Set mask to 2'b11 mid-packet → the current packet completes, then src0 is granted next.
- Counter wrap: CNT_W=4, 17 single-word packets from src0 → `pkt_cnt[0]`=1; `user` bit=1 on one word appears unchanged on `m_dout[0]`.
